uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Byte-stream UART transmitter for the Chisel core behind the TinyTapeout top-level wrapper. It sits directly downstream of the wrapper. It takes bytes strobed in from the dedicated input pins (`ui_in`, with a valid qualifier) and buffers them in a small FIFO. It serialises them as 8N1 frames onto one output bit that the core routes to a `uo_out` pin. Status outputs give back-pressure and visibility on the remaining `uo_out` bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clock`, input, 1: single clock domain; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high. The core receives it already inverted from `rst_n`.
- `in_data`, input, 8: byte to transmit.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: FIFO can accept a byte; equals `!full`.
- `tx`, output, 1: serial line; registered output; idle high.
- `busy`, output, 1: a frame is in flight (FSM not IDLE).
- `fifo_count`, output, log2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: on a rising edge where `in_valid && in_ready`, `in_data` is written to the FIFO. With `in_valid` while full, the byte is dropped silently.
- `in_ready` depends only on the registered full flag. A pop in the same cycle does not let a full FIFO accept a byte.
- Simultaneous push and pop when not full: `fifo_count` is unchanged, and both operations occur.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and the baud counter, then go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], sent LSB first. Shift right every `CLKS_PER_BIT` cycles. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START, so frames are back-to-back with no idle gap.
    - FIFO empty: go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps, generating a bit tick. It is held at 0 in IDLE.
- Bit counter: 3 bits, 0..7; it is used in DATA only.
- `busy`=1 in START, DATA and STOP.
- Reset, including assertion mid-frame, takes effect immediately and asynchronously:
  - `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
  - The FSM returns to IDLE, the FIFO is flushed, and any partial frame is abandoned.
- After reset deasserts, the first transmission starts only from a new push.

## Timing
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
- Latency with FIFO empty and FSM in IDLE, byte accepted at edge N:
  - `fifo_count`=1 after edge N.
  - At edge N+1 the FSM pops. `tx` goes 0 and `busy` goes 1 after edge N+1, and `fifo_count` returns to 0.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins at the edge that ends the stop bit.
- `in_ready` updates one cycle after the push or pop that changes the full state.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, STOP.
  - Frame constants: data bits = 8, stop bits = 1, start level = 0, idle level = 1.
  - Counter-width helper.
- One natural sub-module, `sync_fifo`, parameterised on width (8) and `DEPTH`:
  - Pointers carry one wrap bit for full/empty detection.
  - Outputs `full`, `empty`, `count`, and the head data.
- `uart_tx_stream` contains the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- Reset mid-frame: assert `reset` during DATA of byte 0x55.
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock.
  - After release, `fifo_count`=0, and `tx` stays 1 with no pushes.
- Single byte, `CLKS_PER_BIT`=4: push 0xA5 at edge N.
  - `tx` low from edge N+1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop bit high.
  - `busy` drops after 40 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - The second start bit follows the first stop bit with no idle cycle.
  - Total `busy` time is 80 cycles.
- Full FIFO, `DEPTH`=4: push 6 bytes 0x01..0x06 on consecutive cycles.
  - The first is popped; the next four fill the FIFO.
  - `in_ready`=0 and the sixth byte is dropped.
  - Decoded output is 0x01..0x05 only.
- Full plus pop: hold `in_valid` high while full, across the cycle where the FSM pops.
  - No push is accepted in the pop cycle.
  - A push is accepted the following cycle, when `in_ready`=1.
- Push-while-pop: push in the same cycle the FSM pops, with `fifo_count`=2.
  - `fifo_count` stays 2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the byte-stream UART transmitter: FSM encoding,
// 8N1 frame constants and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   DATA_BITS   = 8;
  localparam int   STOP_BITS   = 1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Byte-input and status bundle of the UART transmitter.
interface uart_tx_stream_if import uart_pkg::*; #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is a registered-full view; a valid byte offered while in_ready
  // is low is dropped, not held.
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  tx_state_e     state;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx, busy, fifo_count, state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx, busy, fifo_count, state
  );

endinterface

// File: rtl/uart_tx_stream_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data is visible while not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed from a small byte FIFO; frames run back-to-back
// while bytes are queued.
module uart_tx_stream import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4
) (
  input logic             clock,
  input logic             reset,
  uart_tx_stream_if.slave bus
);
  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam int             BW        = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;

  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx_q;
  logic          busy_q;
  logic          baud_tick;

  assign baud_tick = (baud == BAUD_LAST);
  assign push      = bus.in_valid && !full;
  // Pop from IDLE immediately, or at the last cycle of a stop bit so the
  // next start bit begins without an idle gap.
  assign pop       = !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_tick));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (bus.in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud <= '0;
          if (pop) begin
            shift   <= head;
            bit_cnt <= '0;
            tx_q    <= START_LEVEL;
            busy_q  <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            baud  <= '0;
            tx_q  <= shift[0];
            state <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx_q  <= IDLE_LEVEL;
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            baud <= '0;
            if (pop) begin
              shift   <= head;
              bit_cnt <= '0;
              tx_q    <= START_LEVEL;
              state   <= ST_START;
            end else begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          baud   <= '0;
          tx_q   <= IDLE_LEVEL;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = !full;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;
  assign bus.state      = state;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Randomised and directed checks of uart_tx_stream against a frame-timeline
// model and a line decoder.
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_tx_stream_if #(.DEPTH(DEPTH)) bus();

  uart_tx_stream #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];      // bytes accepted, in the order they must appear on tx
  logic [7:0] model_q[$];    // model FIFO contents
  int         frame_left  = 0;  // cycles remaining in the frame on the line
  logic [7:0] cur_byte    = '0;
  bit         dec_active  = 0;
  int         dec_t       = 0;
  logic [7:0] dec_byte    = '0;
  int         busy_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level from position inside the 10-bit frame.
  function automatic logic exp_tx();
    int idx;
    if (frame_left == 0) return 1'b1;
    idx = (FRAME - frame_left) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur_byte[idx-1];
    return 1'b1;
  endfunction

  // One rising edge of the model: the line takes the next queued byte when it is
  // free or its frame ends now; a byte is accepted only if the queue was not full.
  task automatic model_edge(input logic v, input logic [7:0] d);
    bit accept;
    bit do_pop;
    accept = v && (model_q.size() < DEPTH);
    do_pop = (model_q.size() > 0) && (frame_left <= 1);
    if (frame_left > 0) frame_left--;
    if (do_pop) begin
      cur_byte   = model_q.pop_front();
      frame_left = FRAME;
    end
    if (accept) begin
      model_q.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  // Mid-bit sampling decoder on the observed line.
  task automatic decode_sample();
    int k;
    if (!dec_active) begin
      if (bus.tx == 1'b0) begin
        dec_active = 1;
        dec_t      = 0;
      end
    end else begin
      dec_t++;
      if (dec_t % CPB == CPB / 2) begin
        k = dec_t / CPB;
        if (k >= 1 && k <= 8) begin
          dec_byte[k-1] = bus.tx;
        end else if (k == 9) begin
          check("stop_bit", bus.tx, 1);
          check("dec_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("dec_byte", dec_byte, exp_q.pop_front());
          dec_active = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clock);
    #1;
    model_edge(v, d);
    check("tx",         bus.tx,         exp_tx());
    check("busy",       bus.busy,       frame_left > 0);
    check("fifo_count", bus.fifo_count, model_q.size());
    check("in_ready",   bus.in_ready,   model_q.size() < DEPTH);
    if (bus.busy) busy_cycles++;
    decode_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  // Asserts reset between edges and checks the outputs before any clock.
  task automatic async_reset();
    #2;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_tx",         bus.tx,         1);
    check("rst_busy",       bus.busy,       0);
    check("rst_in_ready",   bus.in_ready,   1);
    check("rst_fifo_count", bus.fifo_count, 0);
    model_q.delete();
    exp_q.delete();
    frame_left = 0;
    dec_active = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("reset_tx",         bus.tx,         1);
    check("reset_busy",       bus.busy,       0);
    check("reset_in_ready",   bus.in_ready,   1);
    check("reset_fifo_count", bus.fifo_count, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);

    // Single byte 0xA5
    busy_cycles = 0;
    cycle(1'b1, 8'hA5);
    check("single_count", bus.fifo_count, 1);
    idle(50);
    check("single_busy_len", busy_cycles, 40);

    // Back-to-back 0x00, 0xFF
    busy_cycles = 0;
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    idle(90);
    check("b2b_busy_len", busy_cycles, 80);

    // Overfill: six pushes, the sixth must be dropped
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
    idle(5 * FRAME + 10);

    // Hold valid while full across several pops
    for (int i = 0; i < 140; i++) cycle(1'b1, 8'($urandom_range(0, 255)));
    idle(5 * FRAME + 10);

    // Push in the pop cycle with two bytes queued
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    while (frame_left != 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h44);
    check("push_pop_count", bus.fifo_count, 2);
    idle(4 * FRAME + 10);

    // Reset during the data bits of 0x55
    cycle(1'b1, 8'h55);
    idle(20);
    check("midframe_state", bus.state, ST_DATA);
    async_reset();
    idle(60);

    // Random traffic at varying offered load
    for (int i = 0; i < 900; i++) begin
      int rate;
      rate = (i < 300) ? 5 : (i < 600) ? 30 : 80;
      cycle($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
    end
    idle(5 * FRAME + 10);

    check("undelivered_bytes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
